hub75_capture: RTL

- HUB75 sink: the receive end of the LED-panel link that hub75_output drives.
- Oversamples the panel pins on the system clock and rebuilds each shifted line pair (top and bottom half-panel rows) plus its row address.
- Presents each completed line on a valid/ready stream.
- Used for on-board loopback checks of the display path and as the scoreboard front end in system benches.

---
 rtl/hub75_pkg.sv | 17 +
 rtl/hub75_pin_sync.sv | 48 ++++
 rtl/hub75_capture.sv | 164 ++++++++++++++++
 3 files changed

// File: rtl/hub75_pkg.sv
// rtl/hub75_pkg.sv - shared HUB75 types and constants
// Purpose: types shared by the HUB75 source (hub75_output) and sink (hub75_capture).
// Contents:
//   rgb_t         3-bit {r,g,b} pixel as carried on one half-panel data bus
//   HUB75_ADDR_W  row-address width for the default 32-row scan
//   STAT_SHORT    line_status bit: fewer shift clocks than the panel width
//   STAT_LONG     line_status bit: more shift clocks than the panel width
package hub75_pkg;

  typedef logic [2:0] rgb_t;

  localparam int HUB75_ADDR_W = 5;

  localparam int STAT_SHORT = 0;
  localparam int STAT_LONG  = 1;

endpackage

// File: rtl/hub75_pin_sync.sv
// rtl/hub75_pin_sync.sv - multi-flop pin synchronizer with primed change detect
// Purpose: brings WIDTH asynchronous pins into the clk domain and flags changes.
// Ports:
//   clk   in   sampling clock
//   rst   in   asynchronous active-high reset
//   pin   in   raw asynchronous pins
//   sync  out  pins after SYNC_STAGES flops
//   chg   out  per-bit change flag (sync differs from previous sync value),
//              held at 0 for SYNC_STAGES+1 cycles after reset release
module hub75_pin_sync #(
  parameter int WIDTH       = 1,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] pin,
  output logic [WIDTH-1:0] sync,
  output logic [WIDTH-1:0] chg
);

  localparam int PW = $clog2(SYNC_STAGES + 2);
  localparam logic [PW-1:0] PRIME = PW'(SYNC_STAGES + 1);

  logic [SYNC_STAGES-1:0][WIDTH-1:0] stage;
  logic [WIDTH-1:0]                  prev;
  logic [PW-1:0]                     prime;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stage <= '0;
      prev  <= '0;
      prime <= PRIME;
    end else begin
      stage <= {stage[SYNC_STAGES-2:0], pin};
      prev  <= stage[SYNC_STAGES-1];
      if (prime != '0) begin
        prime <= prime - PW'(1);
      end
    end
  end

  assign sync = stage[SYNC_STAGES-1];

  // A pin already high at reset release walks through the cleared chain and
  // would look like a rising edge; the priming count masks that window.
  assign chg = (prime == '0) ? (sync ^ prev) : '0;

endmodule

// File: rtl/hub75_capture.sv
// rtl/hub75_capture.sv - HUB75 panel-link sink rebuilding lines onto a valid/ready stream
// Purpose: oversamples HUB75 pins, shifts pixels on hub75_clk rising edges and
//          commits the top/bottom line pair plus row address on hub75_latch rising edges.
// Optional feature macro: HUB75_CAPTURE_OE_CHECK_EN (adds oe_error).
// Ports:
//   clk_in, rst_in           system clock, asynchronous active-high reset
//   hub75_clk/latch/OE       panel shift clock, latch, active-low output enable
//   hub75_addr               row address
//   hub75_rgb0/rgb1          top/bottom half pixel {r,g,b}
//   line0/line1              captured lines, column c at bits [3c+2:3c]
//   line_addr, line_status   captured row address, {long, short} flags
//   tvalid/tready            output line handshake
//   overflow                 one-cycle pulse when a latched line is dropped
//   oe_error                 one-cycle pulse on latch or address change while OE active
module hub75_capture
  import hub75_pkg::*;
#(
  parameter int NUM_COLS    = 64,
  parameter int SCAN_RATE   = 32,
  parameter int SYNC_STAGES = 2
) (
  input  logic                         clk_in,
  input  logic                         rst_in,
  input  logic                         hub75_clk,
  input  logic                         hub75_latch,
  input  logic                         hub75_OE,
  input  logic [$clog2(SCAN_RATE)-1:0] hub75_addr,
  input  logic [2:0]                   hub75_rgb0,
  input  logic [2:0]                   hub75_rgb1,
  output logic [NUM_COLS*3-1:0]        line0,
  output logic [NUM_COLS*3-1:0]        line1,
  output logic [$clog2(SCAN_RATE)-1:0] line_addr,
  output logic [1:0]                   line_status,
  output logic                         tvalid,
  input  logic                         tready,
  output logic                         overflow
`ifdef HUB75_CAPTURE_OE_CHECK_EN
  ,
  output logic                         oe_error
`endif
);

  localparam int AW = $clog2(SCAN_RATE);
  localparam int LW = NUM_COLS * 3;
  localparam int CW = $clog2(NUM_COLS + 2);
  localparam logic [CW-1:0] COLS = CW'(NUM_COLS);
  localparam logic [CW-1:0] SAT  = CW'(NUM_COLS + 1);

  logic [1:0]    ctrl_sync;
  logic [1:0]    ctrl_chg;
  logic [5:0]    rgb_sync;
  logic [5:0]    rgb_chg_unused;
  logic [AW-1:0] addr_sync;
  logic [AW-1:0] addr_chg;
  logic          shift_edge;
  logic          latch_edge;
  rgb_t          rgb0_s;
  rgb_t          rgb1_s;

  hub75_pin_sync #(.WIDTH(2), .SYNC_STAGES(SYNC_STAGES)) u_ctrl_sync (
    .clk  (clk_in),
    .rst  (rst_in),
    .pin  ({hub75_latch, hub75_clk}),
    .sync (ctrl_sync),
    .chg  (ctrl_chg)
  );

  hub75_pin_sync #(.WIDTH(6), .SYNC_STAGES(SYNC_STAGES)) u_rgb_sync (
    .clk  (clk_in),
    .rst  (rst_in),
    .pin  ({hub75_rgb1, hub75_rgb0}),
    .sync (rgb_sync),
    .chg  (rgb_chg_unused)
  );

  hub75_pin_sync #(.WIDTH(AW), .SYNC_STAGES(SYNC_STAGES)) u_addr_sync (
    .clk  (clk_in),
    .rst  (rst_in),
    .pin  (hub75_addr),
    .sync (addr_sync),
    .chg  (addr_chg)
  );

  assign shift_edge = ctrl_chg[0] & ctrl_sync[0];
  assign latch_edge = ctrl_chg[1] & ctrl_sync[1];
  assign rgb0_s     = rgb_sync[2:0];
  assign rgb1_s     = rgb_sync[5:3];

  logic [LW-1:0] shift0, shift1, shift0_nxt, shift1_nxt;
  logic [CW-1:0] count, count_nxt;
  logic          accept;

  // Shift is resolved before the latch looks at it, so a coincident shift
  // and latch edge capture the new pixel in column 0.
  always_comb begin
    shift0_nxt = shift0;
    shift1_nxt = shift1;
    count_nxt  = count;
    if (shift_edge) begin
      shift0_nxt = {shift0[LW-4:0], rgb0_s};
      shift1_nxt = {shift1[LW-4:0], rgb1_s};
      if (count != SAT) begin
        count_nxt = count + CW'(1);
      end
    end
  end

  assign accept = !tvalid || tready;

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      shift0      <= '0;
      shift1      <= '0;
      count       <= '0;
      line0       <= '0;
      line1       <= '0;
      line_addr   <= '0;
      line_status <= '0;
      tvalid      <= 1'b0;
      overflow    <= 1'b0;
    end else begin
      shift0   <= shift0_nxt;
      shift1   <= shift1_nxt;
      count    <= latch_edge ? '0 : count_nxt;
      overflow <= latch_edge && !accept;
      if (latch_edge && accept) begin
        line0                   <= shift0_nxt;
        line1                   <= shift1_nxt;
        line_addr               <= addr_sync;
        line_status[STAT_SHORT] <= (count_nxt < COLS);
        line_status[STAT_LONG]  <= (count_nxt > COLS);
        tvalid                  <= 1'b1;
      end else if (tready) begin
        tvalid <= 1'b0;
      end
    end
  end

`ifdef HUB75_CAPTURE_OE_CHECK_EN
  logic oe_sync;
  logic oe_chg_unused;

  hub75_pin_sync #(.WIDTH(1), .SYNC_STAGES(SYNC_STAGES)) u_oe_sync (
    .clk  (clk_in),
    .rst  (rst_in),
    .pin  (hub75_OE),
    .sync (oe_sync),
    .chg  (oe_chg_unused)
  );

  // Latching or re-addressing while the panel is lit shows up as ghosting.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      oe_error <= 1'b0;
    end else begin
      oe_error <= !oe_sync && (latch_edge || (addr_chg != '0));
    end
  end
`else
  logic oe_check_unused;
  assign oe_check_unused = ^{addr_chg, hub75_OE};
`endif

endmodule
